// File: rtl/shift_op_sequencer_if.sv
// Command, barrel-shifter and result signals of the shift-op sequencer.
// The slave side is the sequencer; the master side is the command source plus the shifter.
interface shift_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic [LEN_W-1:0] in_len;
    logic [WIDTH-1:0] bs_data;
    logic             bs_direction;
    logic [LEN_W-1:0] bs_len;
    logic [WIDTH-1:0] bs_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    modport master (
        output in_valid, in_data, in_op, in_len, out_ready, bs_out,
        input  in_ready, bs_data, bs_direction, bs_len, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_data, in_op, in_len, out_ready, bs_out,
        output in_ready, bs_data, bs_direction, bs_len, out_valid, out_result
    );
endinterface

// File: rtl/shift_op_sequencer.sv
// Sequences shift commands through an external logical barrel shifter.
// SRA and ROL are built from two logical passes OR-ed together.
module shift_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    shift_op_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PASS1 = 2'd1;
    localparam logic [1:0] PASS2 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic             sign_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] bs_data_q;
    logic             bs_dir_q;
    logic [LEN_W-1:0] bs_len_q;
    logic [WIDTH-1:0] result_q;
    logic             accept;
    logic             need_pass2;
    logic             first_dir;
    logic [LEN_W-1:0] len2;

    assign bus.in_ready     = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid    = (state == DONE);
    assign bus.bs_data      = bs_data_q;
    assign bus.bs_direction = bs_dir_q;
    assign bus.bs_len       = bs_len_q;
    assign bus.out_result   = result_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign first_dir = (bus.in_op == OP_SRL) || (bus.in_op == OP_SRA);
    // bs_len still holds the command's shift amount during PASS1.
    assign need_pass2 = (bs_len_q != '0) &&
                        (((op_q == OP_SRA) && sign_q) || (op_q == OP_ROL));
    assign len2 = -bs_len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_SLL;
            sign_q    <= 1'b0;
            acc       <= '0;
            bs_data_q <= '0;
            bs_dir_q  <= 1'b0;
            bs_len_q  <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.in_op;
                        sign_q    <= bus.in_data[WIDTH-1];
                        bs_data_q <= bus.in_data;
                        bs_dir_q  <= first_dir;
                        bs_len_q  <= bus.in_len;
                        state     <= PASS1;
                    end
                end
                PASS1: begin
                    acc <= bus.bs_out;
                    if (need_pass2) begin
                        // ROL reuses the original operand, already sitting in bs_data.
                        if (op_q == OP_SRA) begin
                            bs_data_q <= '1;
                        end
                        bs_dir_q <= (op_q == OP_ROL);
                        bs_len_q <= len2;
                        state    <= PASS2;
                    end else begin
                        result_q <= bus.bs_out;
                        state    <= DONE;
                    end
                end
                PASS2: begin
                    result_q <= acc | bus.bs_out;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (accept) begin
                            op_q      <= bus.in_op;
                            sign_q    <= bus.in_data[WIDTH-1];
                            bs_data_q <= bus.in_data;
                            bs_dir_q  <= first_dir;
                            bs_len_q  <= bus.in_len;
                            state     <= PASS1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_op_sequencer.sv
// Bench for shift_op_sequencer: models the barrel shifter and checks results
// against arithmetic definitions of SLL/SRL/SRA/ROL.
module tb_shift_op_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    shift_op_sequencer_if #(.WIDTH(32), .LEN_W(5)) bus ();

    // Combinational logical barrel shifter.
    assign bus.bs_out = bus.bs_direction ? (bus.bs_data >> bus.bs_len) : (bus.bs_data << bus.bs_len);

    shift_op_sequencer #(.WIDTH(32), .LEN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] d, input int l);
        logic [31:0] r;
        case (op)
            2'b00: r = d << l;
            2'b01: r = d >> l;
            2'b10: r = $unsigned($signed(d) >>> l);
            default: r = (l == 0) ? d : ((d << l) | (d >> (32 - l)));
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] l,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_len   = l;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 99;
        res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                res = bus.out_result;
                break;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.bs_data !== 32'h0) begin n_err++; $display("FAIL reset_bs_data got %h want 0", bus.bs_data); end
        n_cmp++; if (bus.bs_direction !== 1'b0) begin n_err++; $display("FAIL reset_bs_dir got %b want 0", bus.bs_direction); end
        n_cmp++; if (bus.bs_len !== 5'd0) begin n_err++; $display("FAIL reset_bs_len got %0d want 0", bus.bs_len); end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL reset_out_result got %h want 0", bus.out_result); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b10;
        bus.in_data  = 32'h8000_0000;
        bus.in_len   = 5'd4;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_idle_valid cyc %0d got %b want 0", i, bus.out_valid); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle_ready cyc %0d got %b want 1", i, bus.in_ready); end
        end
        n_cmp++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL midrst_result got %h want 0", bus.out_result); end
    endtask

    task automatic test_sll_sweep();
        logic [31:0] res;
        logic [31:0] ones;
        int lat;
        ones = 32'hFFFF_FFFF;
        for (int l = 0; l < 32; l++) begin
            run_op(2'b00, ones, 5'(l), res, lat);
            n_cmp++; if (res !== (ones << l)) begin n_err++; $display("FAIL sll_len%0d got %h want %h", l, res, ones << l); end
            n_cmp++; if (lat != 1) begin n_err++; $display("FAIL sll_lat_len%0d got %0d want 1", l, lat); end
        end
    endtask

    task automatic test_sra();
        logic [31:0] res;
        int lat;
        run_op(2'b10, 32'h8000_0000, 5'd4, res, lat);
        n_cmp++; if (res !== 32'hF800_0000) begin n_err++; $display("FAIL sra_neg got %h want f8000000", res); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL sra_neg_lat got %0d want 2", lat); end
        run_op(2'b10, 32'h4000_0000, 5'd4, res, lat);
        n_cmp++; if (res !== 32'h0400_0000) begin n_err++; $display("FAIL sra_pos got %h want 04000000", res); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL sra_pos_lat got %0d want 1", lat); end
        run_op(2'b10, 32'h9ABC_DEF0, 5'd0, res, lat);
        n_cmp++; if (res !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL sra_len0 got %h want 9abcdef0", res); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL sra_len0_lat got %0d want 1", lat); end
        run_op(2'b10, 32'hFFFF_FFFE, 5'd31, res, lat);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sra_len31 got %h want ffffffff", res); end
    endtask

    task automatic test_rol();
        logic [31:0] res;
        int lat;
        run_op(2'b11, 32'h8000_0001, 5'd1, res, lat);
        n_cmp++; if (res !== 32'h0000_0003) begin n_err++; $display("FAIL rol_1 got %h want 00000003", res); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL rol_1_lat got %0d want 2", lat); end
        run_op(2'b11, 32'h1234_5678, 5'd8, res, lat);
        n_cmp++; if (res !== 32'h3456_7812) begin n_err++; $display("FAIL rol_8 got %h want 34567812", res); end
        run_op(2'b11, 32'h1234_5678, 5'd0, res, lat);
        n_cmp++; if (res !== 32'h1234_5678) begin n_err++; $display("FAIL rol_0 got %h want 12345678", res); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL rol_0_lat got %0d want 1", lat); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b01;
        bus.in_data  = 32'hF0F0_F0F0;
        bus.in_len   = 5'd4;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b want 1", bus.out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (bus.out_result !== 32'h0F0F_0F0F) begin n_err++; $display("FAIL stall_hold cyc %0d got %h want 0f0f0f0f", i, bus.out_result); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid cyc %0d got %b want 1", i, bus.out_valid); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b00;
        bus.in_data   = 32'h0000_0001;
        bus.in_len    = 5'd31;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_pass1_valid got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_done_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_result !== 32'h8000_0000) begin n_err++; $display("FAIL b2b_result got %h want 80000000", bus.out_result); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        logic [1:0]  op;
        logic [31:0] d;
        int          l;
        int          sent;
        int          got;
        int          cyc;
        bit          pend;
        localparam int N = 300;
        sent = 0; got = 0; cyc = 0; pend = 1'b0;
        op = 2'b00; d = 32'h0; l = 0;
        while ((sent < N || exp_q.size() != 0 || pend) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < N) begin
                op = 2'($urandom_range(0, 3));
                d  = $urandom();
                case ($urandom_range(0, 7))
                    0: l = 0;
                    1: l = 31;
                    default: l = $urandom_range(0, 31);
                endcase
                pend = 1'b1;
            end
            bus.in_valid  = pend && ($urandom_range(0, 3) != 0);
            bus.in_op     = op;
            bus.in_data   = d;
            bus.in_len    = 5'(l);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra_result got %h want none", bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (bus.out_result !== e) begin
                        n_err++;
                        $display("FAIL rand_result idx %0d got %h want %h", got, bus.out_result, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(op, d, l));
                sent++;
                pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++; if (got != N) begin n_err++; $display("FAIL rand_count got %0d want %0d", got, N); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = 32'h0;
        bus.in_len    = 5'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sll_sweep();
        test_sra();
        test_rol();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
